// File: rtl/wb_scratch_pkg.sv
// Shared constants for the Wishbone scratch responder: register map, field
// positions, ID word and the acknowledge FSM states.
package wb_scratch_pkg;

   localparam logic [31:0] ADR_CONTROL  = 32'h0000_0000;
   localparam logic [31:0] ADR_STATUS   = 32'h0000_0001;
   localparam logic [31:0] ADR_DOORBELL = 32'h0000_0002;
   localparam logic [31:0] ADR_ID       = 32'h0000_0003;

   localparam int CTRL_INT_EN    = 0;
   localparam int CTRL_DELAY_LSB = 4;
   localparam int STAT_PENDING   = 0;
   localparam int STAT_WRCNT_LSB = 8;

   localparam logic [31:0] ID_VALUE = 32'hC0C0_7B01;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACK
   } wb_state_e;

endpackage

// File: rtl/wb_scratch_ram.sv
// Byte-enabled scratch memory: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module wb_scratch_ram #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    sel,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (sel[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/wb_scratch_responder.sv
// Wishbone slave with control/status registers, scratch RAM, programmable
// acknowledge delay and a doorbell interrupt.
module wb_scratch_responder
   import wb_scratch_pkg::*;
#(
   parameter int          MEM_DEPTH = 16,
   parameter logic [31:0] MEM_BASE  = 32'h10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_wbs_we,
   input  logic [3:0]  i_wbs_sel,
   input  logic        i_wbs_cyc,
   input  logic        i_wbs_stb,
   input  logic [31:0] i_wbs_adr,
   input  logic [31:0] i_wbs_dat,
   output logic        o_wbs_ack,
   output logic [31:0] o_wbs_dat,
   output logic        o_wbs_int
);

   localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   // Asserts asynchronously, releases two edges after rst rises.
   logic [1:0] rst_ff;
   logic       rst_n_sync;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rst_ff <= 2'b00;
      else      rst_ff <= {rst_ff[0], 1'b1};
   end
   assign rst_n_sync = rst_ff[1];

   wb_state_e   state, state_d;
   logic [3:0]  cnt, cnt_d;
   logic        latch;
   logic [31:0] lat_adr, lat_dat;
   logic        lat_we;
   logic [3:0]  lat_sel;
   logic        int_en, pending, irq, ack;
   logic [3:0]  ack_delay;
   logic [7:0]  wr_count;
   logic [31:0] rdat;

   // In IDLE the request is still on the bus; afterwards use the latched copy.
   logic [31:0] cur_adr, cur_dat, mem_off;
   logic        cur_we;
   logic [3:0]  cur_sel;

   assign cur_adr = (state == IDLE) ? i_wbs_adr : lat_adr;
   assign cur_dat = (state == IDLE) ? i_wbs_dat : lat_dat;
   assign cur_we  = (state == IDLE) ? i_wbs_we  : lat_we;
   assign cur_sel = (state == IDLE) ? i_wbs_sel : lat_sel;
   assign mem_off = cur_adr - MEM_BASE;

   logic in_mem, commit, wr_commit;
   assign in_mem = (cur_adr >= MEM_BASE) && (mem_off < MEM_DEPTH);

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      latch   = 1'b0;
      case (state)
         IDLE: begin
            if (i_wbs_cyc && i_wbs_stb) begin
               latch = 1'b1;
               if (ack_delay == 4'd0) begin
                  state_d = ACK;
               end else begin
                  cnt_d   = ack_delay;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (!(i_wbs_cyc && i_wbs_stb)) state_d = IDLE;
            else if (cnt == 4'd1)           state_d = ACK;
            else                            cnt_d   = cnt - 4'd1;
         end
         ACK: begin
            if (!i_wbs_stb) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Side effects happen only on the transition into ACK.
   assign commit    = (state_d == ACK) && (state != ACK);
   assign wr_commit = commit && cur_we;

   logic [31:0] ram_rdata, rd_mux;

   wb_scratch_ram #(.DEPTH(MEM_DEPTH), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (wr_commit && in_mem),
      .sel   (cur_sel),
      .addr  (mem_off[AW-1:0]),
      .wdata (cur_dat),
      .rdata (ram_rdata)
   );

   always_comb begin
      rd_mux = '0;
      case (cur_adr)
         ADR_CONTROL: begin
            rd_mux[CTRL_INT_EN]         = int_en;
            rd_mux[CTRL_DELAY_LSB +: 4] = ack_delay;
         end
         ADR_STATUS: begin
            rd_mux[STAT_PENDING]        = pending;
            rd_mux[STAT_WRCNT_LSB +: 8] = wr_count;
         end
         ADR_ID:  rd_mux = ID_VALUE;
         default: if (in_mem) rd_mux = ram_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         state   <= IDLE;
         cnt     <= '0;
         lat_adr <= '0;
         lat_dat <= '0;
         lat_we  <= 1'b0;
         lat_sel <= '0;
         ack     <= 1'b0;
         rdat    <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         if (latch) begin
            lat_adr <= i_wbs_adr;
            lat_dat <= i_wbs_dat;
            lat_we  <= i_wbs_we;
            lat_sel <= i_wbs_sel;
         end
         ack <= (state_d == ACK);
         if (commit)                rdat <= cur_we ? '0 : rd_mux;
         else if (state_d != ACK)   rdat <= '0;
      end
   end

   // Register fields take byte lane 0 into account; DOORBELL reacts to any write.
   always_ff @(posedge clk or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         int_en    <= 1'b0;
         ack_delay <= '0;
         pending   <= 1'b0;
         wr_count  <= '0;
         irq       <= 1'b0;
      end else begin
         if (wr_commit) begin
            wr_count <= wr_count + 8'd1;
            case (cur_adr)
               ADR_CONTROL: if (cur_sel[0]) begin
                  int_en    <= cur_dat[CTRL_INT_EN];
                  ack_delay <= cur_dat[CTRL_DELAY_LSB +: 4];
               end
               ADR_STATUS:   if (cur_sel[0] && cur_dat[STAT_PENDING]) pending <= 1'b0;
               ADR_DOORBELL: pending <= 1'b1;
               default: ;
            endcase
         end
         irq <= pending & int_en;
      end
   end

   assign o_wbs_ack = ack;
   assign o_wbs_dat = rdat;
   assign o_wbs_int = irq;

endmodule

// File: tb/tb_wb_scratch_responder.sv
// Self-checking bench: directed vector table, hand sequences for delay/abort/
// reset corners, and random traffic against a behavioural register-map model.
module tb_wb_scratch_responder;

   localparam int          MEM_DEPTH = 16;
   localparam logic [31:0] MEM_BASE  = 32'h10;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_wbs_we = 1'b0;
   logic [3:0]  i_wbs_sel = '0;
   logic        i_wbs_cyc = 1'b0;
   logic        i_wbs_stb = 1'b0;
   logic [31:0] i_wbs_adr = '0;
   logic [31:0] i_wbs_dat = '0;
   logic        o_wbs_ack;
   logic [31:0] o_wbs_dat;
   logic        o_wbs_int;

   always #5 clk = ~clk;

   wb_scratch_responder #(.MEM_DEPTH(MEM_DEPTH), .MEM_BASE(MEM_BASE)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_wbs_we  (i_wbs_we),
      .i_wbs_sel (i_wbs_sel),
      .i_wbs_cyc (i_wbs_cyc),
      .i_wbs_stb (i_wbs_stb),
      .i_wbs_adr (i_wbs_adr),
      .i_wbs_dat (i_wbs_dat),
      .o_wbs_ack (o_wbs_ack),
      .o_wbs_dat (o_wbs_dat),
      .o_wbs_int (o_wbs_int)
   );

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h, want %08h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   bit          m_int_en;
   bit [3:0]    m_delay;
   bit          m_pending;
   int          m_wrc;
   logic [31:0] m_mem [MEM_DEPTH];

   task automatic m_reset();
      m_int_en = 0; m_delay = 0; m_pending = 0; m_wrc = 0;
   endtask

   function automatic bit m_is_mem(input logic [31:0] adr);
      return (adr >= MEM_BASE) && (adr < MEM_BASE + MEM_DEPTH);
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] adr);
      logic [7:0] w;
      w = 8'(m_wrc % 256);
      if (adr == 0) return {24'h0, m_delay, 3'b000, m_int_en};
      if (adr == 1) return {16'h0, w, 7'h0, m_pending};
      if (adr == 3) return 32'hC0C0_7B01;
      if (m_is_mem(adr)) return m_mem[adr - MEM_BASE];
      return 32'h0;
   endfunction

   task automatic m_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      int idx;
      m_wrc = (m_wrc + 1) % 256;
      if (adr == 0 && sel[0]) begin m_int_en = dat[0]; m_delay = dat[7:4]; end
      if (adr == 1 && sel[0] && dat[0]) m_pending = 0;
      if (adr == 2) m_pending = 1;
      if (m_is_mem(adr)) begin
         idx = adr - MEM_BASE;
         for (int b = 0; b < 4; b++)
            if (sel[b]) m_mem[idx][8*b +: 8] = dat[8*b +: 8];
      end
   endtask

   // ---------------- bus access ----------------
   // Called and returns at posedge+1. lat counts edges from stb until ack is seen.
   task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rd, output int lat,
                       output logic irq_after);
      i_wbs_we = we; i_wbs_adr = adr; i_wbs_dat = dat; i_wbs_sel = sel;
      i_wbs_cyc = 1'b1; i_wbs_stb = 1'b1;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!o_wbs_ack && lat < 40);
      rd = o_wbs_dat;
      i_wbs_cyc = 1'b0; i_wbs_stb = 1'b0;
      @(posedge clk); #1;
      irq_after = o_wbs_int;
      chk("ack_drop", {31'h0, o_wbs_ack}, 32'h0);
   endtask

   task automatic model_txn(input string tag, input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
      logic [31:0] rd, exp_rd;
      int          lat, exp_lat;
      logic        irq;
      exp_lat = int'(m_delay) + 1;
      exp_rd  = m_read(adr);
      xfer(we, adr, dat, sel, rd, lat, irq);
      if (we) m_write(adr, dat, sel);
      chk({tag, "_lat"}, lat, exp_lat);
      if (!we) chk({tag, "_rd"}, rd, exp_rd);
      chk({tag, "_int"}, {31'h0, irq}, {31'h0, m_pending & m_int_en});
   endtask

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [31:0] exp_dat;
      int          exp_lat;
   } vec_t;

   vec_t vecs[13];

   initial begin
      logic [31:0] rd, adr, dat;
      logic [3:0]  sel;
      int          lat;
      logic        irq, saw_ack, we;

      vecs[0]  = '{1'b0, 32'h03, 32'h0,         4'hF, 32'hC0C0_7B01, 1};
      vecs[1]  = '{1'b0, 32'h00, 32'h0,         4'hF, 32'h0,         1};
      vecs[2]  = '{1'b1, 32'h13, 32'hDEADBEEF,  4'hF, 32'h0,         1};
      vecs[3]  = '{1'b1, 32'h13, 32'h00000011,  4'h1, 32'h0,         1};
      vecs[4]  = '{1'b0, 32'h13, 32'h0,         4'hF, 32'hDEADBE11,  1};
      vecs[5]  = '{1'b0, 32'h01, 32'h0,         4'hF, 32'h00000200,  1};
      vecs[6]  = '{1'b1, 32'h00, 32'h00000050,  4'hF, 32'h0,         1};
      vecs[7]  = '{1'b0, 32'h03, 32'h0,         4'hF, 32'hC0C0_7B01, 6};
      vecs[8]  = '{1'b1, 32'h00, 32'h00000001,  4'hF, 32'h0,         6};
      vecs[9]  = '{1'b0, 32'h00, 32'h0,         4'hF, 32'h00000001,  1};
      vecs[10] = '{1'b0, 32'h02, 32'h0,         4'hF, 32'h0,         1};
      vecs[11] = '{1'b0, 32'h7F, 32'h0,         4'hF, 32'h0,         1};
      vecs[12] = '{1'b0, 32'h01, 32'h0,         4'hF, 32'h00000400,  1};

      m_reset();
      for (int i = 0; i < MEM_DEPTH; i++) m_mem[i] = 'x;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", {31'h0, o_wbs_ack}, 32'h0);
      chk("rst_dat", o_wbs_dat, 32'h0);
      chk("rst_int", {31'h0, o_wbs_int}, 32'h0);
      rst = 1'b1;
      repeat (2) begin @(posedge clk); #1; end

      // Directed table
      for (int i = 0; i < 13; i++) begin
         xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd, lat, irq);
         if (vecs[i].we) m_write(vecs[i].adr, vecs[i].dat, vecs[i].sel);
         chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
         if (!vecs[i].we) chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_dat);
      end

      // Doorbell interrupt and W1C
      xfer(1'b1, 32'h2, 32'h0, 4'hF, rd, lat, irq); m_write(32'h2, 32'h0, 4'hF);
      chk("int_doorbell", {31'h0, irq}, 32'h1);
      xfer(1'b1, 32'h1, 32'h0, 4'hF, rd, lat, irq); m_write(32'h1, 32'h0, 4'hF);
      chk("int_w0_keeps", {31'h0, irq}, 32'h1);
      xfer(1'b1, 32'h1, 32'h1, 4'hF, rd, lat, irq); m_write(32'h1, 32'h1, 4'hF);
      chk("int_w1c", {31'h0, irq}, 32'h0);
      xfer(1'b1, 32'h2, 32'h0, 4'hF, rd, lat, irq); m_write(32'h2, 32'h0, 4'hF);
      xfer(1'b1, 32'h2, 32'h0, 4'hF, rd, lat, irq); m_write(32'h2, 32'h0, 4'hF);
      xfer(1'b0, 32'h1, 32'h0, 4'hF, rd, lat, irq);
      chk("dbl_doorbell_status", rd, 32'h0000_0901);
      xfer(1'b1, 32'h1, 32'h1, 4'hF, rd, lat, irq); m_write(32'h1, 32'h1, 4'hF);

      // Abort during WAIT: no ack, no write, no count
      xfer(1'b1, MEM_BASE + 5, 32'h12345678, 4'hF, rd, lat, irq);
      m_write(MEM_BASE + 5, 32'h12345678, 4'hF);
      xfer(1'b1, 32'h0, 32'h51, 4'hF, rd, lat, irq); m_write(32'h0, 32'h51, 4'hF);
      i_wbs_we = 1'b1; i_wbs_adr = MEM_BASE + 5; i_wbs_dat = 32'hAAAAAAAA; i_wbs_sel = 4'hF;
      i_wbs_cyc = 1'b1; i_wbs_stb = 1'b1;
      saw_ack = 1'b0;
      repeat (3) begin @(posedge clk); #1; if (o_wbs_ack) saw_ack = 1'b1; end
      i_wbs_cyc = 1'b0; i_wbs_stb = 1'b0;
      repeat (8) begin @(posedge clk); #1; if (o_wbs_ack) saw_ack = 1'b1; end
      chk("abort_no_ack", {31'h0, saw_ack}, 32'h0);
      xfer(1'b1, 32'h0, 32'h01, 4'hF, rd, lat, irq); m_write(32'h0, 32'h01, 4'hF);
      chk("delay5_write_lat", lat, 6);
      xfer(1'b0, MEM_BASE + 5, 32'h0, 4'hF, rd, lat, irq);
      chk("abort_mem_kept", rd, 32'h12345678);
      xfer(1'b0, 32'h1, 32'h0, 4'hF, rd, lat, irq);
      chk("abort_wrcount", rd, 32'h0000_0D00);

      // 256 unmapped writes wrap wr_count back to where it was
      for (int i = 0; i < 256; i++) begin
         xfer(1'b1, 32'h7F, $urandom, 4'hF, rd, lat, irq);
         m_write(32'h7F, 32'h0, 4'hF);
      end
      xfer(1'b0, 32'h1, 32'h0, 4'hF, rd, lat, irq);
      chk("wrap_wrcount", rd, 32'h0000_0D00);
      model_txn("unmapped", 1'b0, 32'h7F, 32'h0, 4'hF);

      // Fill scratch so every later read is defined, then random traffic
      for (int i = 0; i < MEM_DEPTH; i++)
         model_txn("fill", 1'b1, MEM_BASE + i, $urandom, 4'hF);
      for (int i = 0; i < 200; i++) begin
         int r;
         r   = $urandom_range(0, 9);
         we  = 1'($urandom_range(0, 1));
         dat = $urandom;
         sel = 4'hF;
         if (r < 4) adr = 32'(r);
         else if (r < 8) begin adr = MEM_BASE + $urandom_range(0, MEM_DEPTH - 1); sel = 4'($urandom); end
         else if (r == 8) adr = 32'($urandom_range(4, 15));
         else adr = 32'h8000_0000 | $urandom;
         model_txn("rand", we, adr, dat, sel);
      end

      // Reset during WAIT: immediate ack/int low, write lost, 3-edge release
      model_txn("pre_rst_ctl", 1'b1, 32'h0, 32'h51, 4'hF);
      model_txn("pre_rst_db", 1'b1, 32'h2, 32'h0, 4'hF);
      i_wbs_we = 1'b1; i_wbs_adr = MEM_BASE + 3; i_wbs_dat = 32'h55555555; i_wbs_sel = 4'hF;
      i_wbs_cyc = 1'b1; i_wbs_stb = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
      #1;
      chk("midrst_ack", {31'h0, o_wbs_ack}, 32'h0);
      chk("midrst_int", {31'h0, o_wbs_int}, 32'h0);
      i_wbs_cyc = 1'b0; i_wbs_stb = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      m_reset();
      xfer(1'b0, MEM_BASE + 3, 32'h0, 4'hF, rd, lat, irq);
      chk("rst_release_lat", lat, 3);
      chk("midrst_mem_kept", rd, m_mem[3]);
      model_txn("post_rst_status", 1'b0, 32'h1, 32'h0, 4'hF);

      // Reset while ack is high drops it immediately
      i_wbs_we = 1'b0; i_wbs_adr = 32'h3; i_wbs_cyc = 1'b1; i_wbs_stb = 1'b1;
      @(posedge clk); #1;
      chk("ack_before_rst", {31'h0, o_wbs_ack}, 32'h1);
      rst = 1'b0;
      #1;
      chk("ackrst_ack", {31'h0, o_wbs_ack}, 32'h0);
      chk("ackrst_dat", o_wbs_dat, 32'h0);
      i_wbs_cyc = 1'b0; i_wbs_stb = 1'b0;
      repeat (2) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
